srsystem_rc: RTL and testbench

SRSYSTEM_RC -- requirements
Module: srsystem_rc

---
 rtl/srsystem_pkg.sv | 16 +
 rtl/srsystem_chk.sv | 23 ++
 rtl/srsystem_rc.sv | 110 +++++++++++
 tb/tb_srsystem_rc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/srsystem_pkg.sv
// srsystem_pkg -- shared definitions for the serial receive controller.
//   state_t        : controller state encoding (IDLE, RECV, CHECK)
//   FRAME_BITS_DEF : default serial bits per frame (start + 8 data + parity + stop)
//   PARITY_ODD     : parity mode; a frame is good when ^{data,parity} equals this
package srsystem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam int   FRAME_BITS_DEF = 11;
    localparam logic PARITY_ODD     = 1'b1;

endpackage

// File: rtl/srsystem_chk.sv
// srsystem_chk -- combinational frame check on the aligned shift register.
//   q[7:0]  : data bits          qst : start-bit position
//   opn     : parity-bit position qsp : stop-bit position
//   good    : frame passes both parity and framing tests
//   perr_n  : parity test fails (next-cycle value of perr)
//   ferr_n  : framing test fails (next-cycle value of ferr)
module srsystem_chk
    import srsystem_pkg::*;
(
    input  logic [7:0] q,
    input  logic       qst,
    input  logic       opn,
    input  logic       qsp,
    output logic       good,
    output logic       perr_n,
    output logic       ferr_n
);

    assign perr_n = ((^q) ^ opn) != PARITY_ODD;
    assign ferr_n = qst | ~qsp;
    assign good   = ~perr_n & ~ferr_n;

endmodule

// File: rtl/srsystem_rc.sv
// srsystem_rc -- receive controller for an external serial shift register.
//   rxclk  : bit-rate clock          clr    : async active-high reset
//   rx     : serial line (idle high) q/qst/opn/qsp : shift-register taps
//   dready : consumer accepts dout   dout/dvalid   : delivered byte
//   perr/ferr : one-cycle error pulses  ovr : sticky overrun
//   errcnt : saturating bad-frame count busy : RECV or CHECK
module srsystem_rc
    import srsystem_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int ERRW       = 8
) (
    input  logic            rxclk,
    input  logic            clr,
    input  logic            rx,
    input  logic [7:0]      q,
    input  logic            qst,
    input  logic            opn,
    input  logic            qsp,
    input  logic            dready,
    output logic [7:0]      dout,
    output logic            dvalid,
    output logic            perr,
    output logic            ferr,
    output logic            ovr,
    output logic [ERRW-1:0] errcnt,
    output logic            busy
);

    localparam logic [3:0] LAST = 4'(FRAME_BITS - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       good, perr_n, ferr_n;
    logic [7:0] rev;

    srsystem_chk u_chk (
        .q      (q),
        .qst    (qst),
        .opn    (opn),
        .qsp    (qsp),
        .good   (good),
        .perr_n (perr_n),
        .ferr_n (ferr_n)
    );

    // q[7] is the first bit on the wire, which is the data LSB.
    always_comb begin
        rev = '0;
        for (int i = 0; i < 8; i++) rev[i] = q[7-i];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge rxclk or posedge clr) begin
        if (clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
            errcnt <= '0;
        end else begin
            perr <= 1'b0;
            ferr <= 1'b0;
            // Consumer handshake; a load in CHECK below overrides this.
            if (dvalid && dready) dvalid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rx) begin
                        state <= S_RECV;
                        cnt   <= 4'd1;
                    end
                end
                S_RECV: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) state <= S_CHECK;
                end
                S_CHECK: begin
                    perr <= perr_n;
                    ferr <= ferr_n;
                    if (!good) begin
                        if (errcnt != '1) errcnt <= errcnt + ERRW'(1);
                    end else if (!dvalid || dready) begin
                        dout   <= rev;
                        dvalid <= 1'b1;
                    end else begin
                        ovr <= 1'b1;
                    end
                    // rx at this edge may already be the next start bit.
                    if (!rx) begin
                        state <= S_RECV;
                        cnt   <= 4'd1;
                    end else begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srsystem_rc.sv
// tb_srsystem_rc -- randomized bench with a frame-level reference model.
//   Builds a bit stream of frames (with per-edge dready), feeds it through a
//   bench-side shift register, and compares every output after every edge.
module tb_srsystem_rc;

    localparam int FB   = 11;
    localparam int ERRW = 8;

    logic            rxclk = 1'b0;
    logic            clr   = 1'b0;
    logic            rx    = 1'b1;
    logic            dready = 1'b0;
    logic [7:0]      dout;
    logic            dvalid, perr, ferr, ovr, busy;
    logic [ERRW-1:0] errcnt;

    // External shift register: first received bit ends up at the top.
    logic [FB-1:0] sr = '1;
    always @(posedge rxclk) sr <= {sr[FB-2:0], rx};

    srsystem_rc #(.FRAME_BITS(FB), .ERRW(ERRW)) dut (
        .rxclk  (rxclk),
        .clr    (clr),
        .rx     (rx),
        .q      (sr[9:2]),
        .qst    (sr[10]),
        .opn    (sr[1]),
        .qsp    (sr[0]),
        .dready (dready),
        .dout   (dout),
        .dvalid (dvalid),
        .perr   (perr),
        .ferr   (ferr),
        .ovr    (ovr),
        .errcnt (errcnt),
        .busy   (busy)
    );

    always #5 rxclk = ~rxclk;

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus stream and per-frame expectations.
    logic bitq[$];
    logic rdyq[$];
    logic bsyq[$];
    int   fchk[$];
    logic [7:0] fbyte[$];
    logic fpbad[$];
    logic fsbad[$];
    int   policy;

    // Reference model state.
    logic [7:0]      m_dout;
    logic            m_dv, m_perr, m_ferr, m_ovr;
    logic [ERRW-1:0] m_err;

    task automatic model_reset();
        m_dout = '0; m_dv = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_err = '0;
    endtask

    task automatic new_stream(input int pol);
        bitq.delete(); rdyq.delete(); bsyq.delete();
        fchk.delete(); fbyte.delete(); fpbad.delete(); fsbad.delete();
        policy = pol;
    endtask

    function automatic logic pol_rdy();
        if (policy == 0) return 1'b0;
        if (policy == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_bit(input logic b);
        bitq.push_back(b);
        rdyq.push_back(pol_rdy());
        bsyq.push_back(1'b0);
    endtask

    // Appends one frame after `gap` idle bits; returns the CHECK edge index.
    task automatic add_frame(input logic [7:0] d, input logic pbad, input logic sbad,
                             input int gap, output int cidx);
        int s;
        logic p;
        for (int g = 0; g < gap; g++) push_bit(1'b1);
        s = bitq.size();
        p = ~(^d) ^ pbad;
        push_bit(1'b0);
        for (int k = 0; k < 8; k++) push_bit(d[k]);
        push_bit(p);
        push_bit(~sbad);
        for (int k = 0; k < FB; k++) bsyq[s+k] = 1'b1;
        cidx = s + FB;
        fchk.push_back(cidx);
        fbyte.push_back(d);
        fpbad.push_back(pbad);
        fsbad.push_back(sbad);
    endtask

    // Drives the stream one bit per edge; stops before edge stop_at if >= 0.
    task automatic run_stream(input int stop_at);
        int fi;
        logic load;
        fi = 0;
        for (int k = 0; k < 3; k++) push_bit(1'b1);
        for (int i = 0; i < bitq.size(); i++) begin
            if (i == stop_at) return;
            rx = bitq[i];
            dready = rdyq[i];
            @(posedge rxclk);
            load = 0;
            m_perr = 0;
            m_ferr = 0;
            if (fi < fchk.size() && fchk[fi] == i) begin
                if (fpbad[fi] || fsbad[fi]) begin
                    m_perr = fpbad[fi];
                    m_ferr = fsbad[fi];
                    if (m_err != {ERRW{1'b1}}) m_err = m_err + 1'b1;
                end else if (!m_dv || rdyq[i]) begin
                    m_dout = fbyte[fi];
                    m_dv = 1;
                    load = 1;
                end else begin
                    m_ovr = 1;
                end
                fi++;
            end
            if (!load && m_dv && rdyq[i]) m_dv = 0;
            #1;
            chk("dout", dout, m_dout);
            chk("dvalid", dvalid, m_dv);
            chk("perr", perr, m_perr);
            chk("ferr", ferr, m_ferr);
            chk("ovr", ovr, m_ovr);
            chk("errcnt", errcnt, m_err);
            chk("busy", busy, bsyq[i]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dvalid"}, dvalid, 0);
        chk({tag, "_perr"}, perr, 0);
        chk({tag, "_ferr"}, ferr, 0);
        chk({tag, "_ovr"}, ovr, 0);
        chk({tag, "_errcnt"}, errcnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rx = 1; dready = 0; clr = 1;
        @(posedge rxclk); #1;
        chk_all_zero("rst");
        clr = 0;
        model_reset();
    endtask

    initial begin
        int c, c2, k;
        model_reset();

        // Good, parity-bad, stop-bad frames, nobody consuming.
        do_reset();
        new_stream(0);
        add_frame(8'hA5, 0, 0, 1, c);
        add_frame(8'hA5, 1, 0, 2, c);
        add_frame(8'hA5, 0, 1, 0, c);
        run_stream(-1);
        chk("s1_dout", dout, 8'hA5);
        chk("s1_dvalid", dvalid, 1);
        chk("s1_errcnt", errcnt, 2);

        // Error counter saturation: 2^ERRW+3 bad frames.
        do_reset();
        new_stream(2);
        for (int n = 0; n < (1 << ERRW) + 3; n++) begin
            k = $urandom_range(1, 3);
            add_frame(8'($urandom), k[0], k[1], 0, c);
        end
        run_stream(-1);
        chk("s2_errcnt", errcnt, {ERRW{1'b1}});

        // Back-to-back good frames with no consumer, then one dready edge.
        do_reset();
        new_stream(0);
        add_frame(8'h3C, 0, 0, 1, c);
        add_frame(8'hC3, 0, 0, 0, c);
        push_bit(1'b1); push_bit(1'b1);
        bitq.push_back(1'b1); rdyq.push_back(1'b1); bsyq.push_back(1'b0);
        run_stream(-1);
        chk("s3_dout", dout, 8'h3C);
        chk("s3_ovr", ovr, 1);
        chk("s3_dvalid", dvalid, 0);

        // Second frame completes while dready is high at its CHECK edge.
        do_reset();
        new_stream(0);
        add_frame(8'h3C, 0, 0, 1, c);
        add_frame(8'hC3, 0, 0, 0, c2);
        rdyq[c2] = 1'b1;
        run_stream(-1);
        chk("s4_dout", dout, 8'hC3);
        chk("s4_dvalid", dvalid, 1);
        chk("s4_ovr", ovr, 0);

        // Random frames, gaps and consumer.
        do_reset();
        new_stream(2);
        for (int n = 0; n < 60; n++)
            add_frame(8'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 2), c);
        run_stream(-1);

        // Asynchronous clear in the middle of a frame, then a clean frame.
        do_reset();
        new_stream(0);
        add_frame(8'h96, 0, 0, 1, c);
        run_stream(6);
        rx = 1; dready = 0; clr = 1;
        #1;
        chk_all_zero("midclr");
        #1;
        clr = 0;
        model_reset();
        new_stream(0);
        add_frame(8'h5A, 0, 0, 2, c);
        run_stream(-1);
        chk("s6_dout", dout, 8'h5A);
        chk("s6_dvalid", dvalid, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
